// File: rtl/dmem_wb_pkg.sv
// dmem_wb_pkg: shared types, default depth and lane-merge helper for the data-memory write buffer
package dmem_wb_pkg;
  localparam int WB_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;
  function automatic entry_t merge_entry(entry_t old, logic [31:0] data, logic [3:0] mask);
    merge_entry = old;
    for (int b = 0; b < 4; b++)
      if (mask[b]) merge_entry.data[8*b +: 8] = data[8*b +: 8];
    merge_entry.mask = old.mask | mask;
  endfunction
endpackage

// File: rtl/dmem_wb_fifo.sv
// dmem_wb_fifo: posted-write storage with parallel word-address match; tail merge under DMEM_WB_COALESCE_EN
module dmem_wb_fifo import dmem_wb_pkg::*; #(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wr,
  input  logic [29:0]      match_addr,
`ifdef DMEM_WB_COALESCE_EN
  input  logic             merge,
  input  logic             head_busy,
  output logic             can_merge,
`endif
  output entry_t           head,
  output logic [DEPTH-1:0] match,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] count;
  assign head  = mem[rptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [AW-1:0] off;
    assign off      = AW'(i) - rptr;
    assign match[i] = ({1'b0, off} < count) && mem[i].waddr == match_addr;
  end
`ifdef DMEM_WB_COALESCE_EN
  logic [AW-1:0] tail;
  assign tail      = wptr - 1'b1;
  // a lone entry that is already on the bus must not change underneath it
  assign can_merge = !empty && mem[tail].waddr == wr.waddr && !(count == (AW+1)'(1) && head_busy);
`endif
  always_ff @(posedge clk_in) begin
    if (push) mem[wptr] <= wr;
`ifdef DMEM_WB_COALESCE_EN
    else if (merge) mem[tail] <= merge_entry(mem[tail], wr.data, wr.mask);
`endif
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posts core stores to a FIFO and drains them to a valid/ready bus; loads bypass unless they hit a pending store.
// Define DMEM_WB_COALESCE_EN to merge same-word stores into the FIFO tail entry.
module dmem_write_buffer import dmem_wb_pkg::*; #(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        core_wr_req_in,
  input  logic        core_rd_req_in,
  input  logic [31:0] core_addr_in,
  input  logic [31:0] core_wdata_in,
  input  logic [3:0]  core_wr_mask_in,
  output logic        stall_out,
  output logic [31:0] core_rdata_out,
  output logic        core_rdata_valid_out,
  output logic        bus_valid_out,
  input  logic        bus_ready_in,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_mask_out,
  input  logic [31:0] bus_rdata_in,
  input  logic        bus_rvalid_in
);
  state_t state;
  entry_t head, wr;
  logic [DEPTH-1:0] match;
  logic full, empty, rd_pend, hazard, issue_rd, load_wr, pop, push, merge, unused;
  assign unused   = ^core_addr_in[1:0];
  assign wr       = '{waddr: core_addr_in[31:2], data: core_wdata_in, mask: core_wr_mask_in};
  assign rd_pend  = core_rd_req_in && !core_wr_req_in && !core_rdata_valid_out;
  assign hazard   = |match || (state == WR_ISSUE && bus_addr_out[31:2] == core_addr_in[31:2]);
  assign issue_rd = state == IDLE && rd_pend && !hazard;
  assign load_wr  = state == IDLE && !issue_rd && !empty;
  assign pop      = state == WR_ISSUE && bus_ready_in;
`ifdef DMEM_WB_COALESCE_EN
  logic can_merge;
  assign merge = core_wr_req_in && can_merge;
`else
  assign merge = 1'b0;
`endif
  // a pop in the same cycle frees the slot, so the full store is taken without stalling
  assign push      = core_wr_req_in && !merge && (!full || pop);
  assign stall_out = (core_wr_req_in && !merge && full && !pop) || rd_pend;
  dmem_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in, .rst_in, .push, .pop, .wr,
    .match_addr(core_addr_in[31:2]),
`ifdef DMEM_WB_COALESCE_EN
    .merge, .head_busy(state == WR_ISSUE || load_wr), .can_merge,
`endif
    .head, .match, .full, .empty
  );
  always_ff @(posedge clk_in) begin
    core_rdata_valid_out <= 1'b0;
    if (!rst_in) begin
      state          <= IDLE;
      bus_valid_out  <= 1'b0;
      bus_we_out     <= 1'b0;
      bus_addr_out   <= '0;
      bus_wdata_out  <= '0;
      bus_mask_out   <= '0;
      core_rdata_out <= '0;
    end else case (state)
      IDLE: if (issue_rd) begin
        bus_valid_out <= 1'b1;
        bus_we_out    <= 1'b0;
        bus_addr_out  <= {core_addr_in[31:2], 2'b00};
        bus_wdata_out <= '0;
        bus_mask_out  <= 4'hF;
        state         <= RD_ISSUE;
      end else if (load_wr) begin
        bus_valid_out <= 1'b1;
        bus_we_out    <= 1'b1;
        bus_addr_out  <= {head.waddr, 2'b00};
        bus_wdata_out <= head.data;
        bus_mask_out  <= head.mask;
        state         <= WR_ISSUE;
      end
      WR_ISSUE: if (bus_ready_in) begin
        bus_valid_out <= 1'b0;
        state         <= IDLE;
      end
      RD_ISSUE: if (bus_ready_in) begin
        bus_valid_out <= 1'b0;
        state         <= RD_WAIT;
      end
      RD_WAIT: if (bus_rvalid_in) begin
        core_rdata_out       <= bus_rdata_in;
        core_rdata_valid_out <= 1'b1;
        state                <= IDLE;
      end
      default: state <= IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer: directed scenario tasks with hand-computed bus beats and load responses
module tb_dmem_write_buffer;
  import dmem_wb_pkg::*;
  logic clk_in = 1'b0, rst_in = 1'b0;
  logic core_wr_req_in = 1'b0, core_rd_req_in = 1'b0;
  logic [31:0] core_addr_in = '0, core_wdata_in = '0;
  logic [3:0] core_wr_mask_in = '0;
  logic stall_out, core_rdata_valid_out, bus_valid_out, bus_we_out;
  logic [31:0] core_rdata_out, bus_addr_out, bus_wdata_out;
  logic [3:0] bus_mask_out;
  logic bus_ready_in = 1'b0, bus_rvalid_in = 1'b0;
  logic [31:0] bus_rdata_in = '0;
  logic [68:0] beats[$];
  int tests = 0, fails = 0;

  always #5 clk_in = ~clk_in;

  dmem_write_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .core_wr_req_in(core_wr_req_in), .core_rd_req_in(core_rd_req_in),
    .core_addr_in(core_addr_in), .core_wdata_in(core_wdata_in), .core_wr_mask_in(core_wr_mask_in),
    .stall_out(stall_out), .core_rdata_out(core_rdata_out), .core_rdata_valid_out(core_rdata_valid_out),
    .bus_valid_out(bus_valid_out), .bus_ready_in(bus_ready_in), .bus_we_out(bus_we_out),
    .bus_addr_out(bus_addr_out), .bus_wdata_out(bus_wdata_out), .bus_mask_out(bus_mask_out),
    .bus_rdata_in(bus_rdata_in), .bus_rvalid_in(bus_rvalid_in)
  );

  // every accepted bus beat as {we, addr, wdata, mask}
  always @(negedge clk_in)
    if (rst_in && bus_valid_out && bus_ready_in)
      beats.push_back({bus_we_out, bus_addr_out, bus_wdata_out, bus_mask_out});

  task automatic step();
    @(posedge clk_in); #2;
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    core_wr_req_in = 1'b1; core_addr_in = a; core_wdata_in = d; core_wr_mask_in = m;
    step();
    core_wr_req_in = 1'b0;
  endtask

  task automatic serve_read(input string name, input int dly, input logic [31:0] d);
    int n = 0;
    @(negedge clk_in);
    while (!(bus_valid_out && bus_ready_in && !bus_we_out) && n < 20) begin
      @(posedge clk_in); #2; @(negedge clk_in); n++;
    end
    tests++; if (n == 20) begin fails++; $display("FAIL %s_rd_issue no read handshake within 20 cycles", name); end
    step();
    repeat (dly - 1) step();
    bus_rvalid_in = 1'b1; bus_rdata_in = d;
    @(negedge clk_in);
    tests++; if ({core_rdata_valid_out, stall_out} !== 2'b01) begin fails++; $display("FAIL %s_pre_pulse got valid,stall=%b%b exp 01", name, core_rdata_valid_out, stall_out); end
    step();
    bus_rvalid_in = 1'b0; bus_rdata_in = '0;
    @(negedge clk_in);
    tests++; if ({core_rdata_valid_out, stall_out, core_rdata_out} !== {2'b10, d}) begin fails++; $display("FAIL %s_pulse got valid=%b stall=%b rdata=%h exp 1 0 %h", name, core_rdata_valid_out, stall_out, core_rdata_out, d); end
    step();
    core_rd_req_in = 1'b0;
    @(negedge clk_in);
    tests++; if (core_rdata_valid_out !== 1'b0) begin fails++; $display("FAIL %s_pulse_len valid stayed %b exp 0", name, core_rdata_valid_out); end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      core_wr_req_in = 1'($urandom); core_rd_req_in = 1'($urandom);
      core_addr_in = $urandom; core_wdata_in = $urandom; core_wr_mask_in = 4'($urandom);
      bus_ready_in = 1'($urandom); bus_rvalid_in = 1'($urandom); bus_rdata_in = $urandom;
      step();
    end
    core_wr_req_in = 1'b0; core_rd_req_in = 1'b0; bus_ready_in = 1'b0; bus_rvalid_in = 1'b0;
    @(negedge clk_in);
    tests++; if ({bus_valid_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_mask_out} !== '0) begin fails++; $display("FAIL reset_bus got v=%b we=%b a=%h d=%h m=%h exp all 0", bus_valid_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_mask_out); end
    tests++; if ({stall_out, core_rdata_valid_out, core_rdata_out} !== '0) begin fails++; $display("FAIL reset_core got stall=%b valid=%b rdata=%h exp 0 0 0", stall_out, core_rdata_valid_out, core_rdata_out); end
    tests++; if (dut.state !== IDLE || dut.u_fifo.empty !== 1'b1) begin fails++; $display("FAIL reset_state got state=%0d empty=%b exp 0 1", dut.state, dut.u_fifo.empty); end
    rst_in = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus_ready_in = 1'b1; beats.delete();
    wr1(32'h100, 32'hDEADBEEF, 4'hF);
    @(negedge clk_in);
    tests++; if (bus_valid_out !== 1'b0) begin fails++; $display("FAIL single_early valid got %b exp 0", bus_valid_out); end
    step();
    @(negedge clk_in);
    tests++; if ({bus_valid_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_mask_out} !== {2'b11, 32'h100, 32'hDEADBEEF, 4'hF}) begin fails++; $display("FAIL single_beat got v=%b we=%b a=%h d=%h m=%h exp 1 1 100 deadbeef f", bus_valid_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_mask_out); end
    repeat (4) step();
    tests++; if (beats.size() != 1) begin fails++; $display("FAIL single_count got %0d beats exp 1", beats.size()); end
  endtask

  task automatic test_fill();
    logic [68:0] e;
    bus_ready_in = 1'b0; beats.delete();
    for (int k = 0; k < 4; k++) begin
      core_wr_req_in = 1'b1; core_addr_in = 32'(4 * k); core_wdata_in = 32'h1000 + 32'(k); core_wr_mask_in = 4'hF;
      @(negedge clk_in);
      tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL fill_stall%0d got %b exp 0", k, stall_out); end
      step();
    end
    core_addr_in = 32'h10; core_wdata_in = 32'h1004;
    repeat (3) begin
      @(negedge clk_in);
      tests++; if (stall_out !== 1'b1) begin fails++; $display("FAIL fill_full_stall got %b exp 1", stall_out); end
      step();
    end
    @(negedge clk_in);
    tests++; if ({bus_valid_out, bus_addr_out, bus_wdata_out} !== {1'b1, 32'h0, 32'h1000}) begin fails++; $display("FAIL fill_hold got v=%b a=%h d=%h exp 1 0 1000", bus_valid_out, bus_addr_out, bus_wdata_out); end
    bus_ready_in = 1'b1;
    #1;
    tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL fill_pop_accept stall got %b exp 0", stall_out); end
    step();
    core_wr_req_in = 1'b0;
    repeat (12) step();
    tests++; if (beats.size() != 5) begin fails++; $display("FAIL fill_count got %0d beats exp 5", beats.size()); end
    for (int k = 0; k < 5; k++) begin
      e = {1'b1, 32'(4 * k), 32'h1000 + 32'(k), 4'hF};
      tests++; if (beats.size() <= k || beats[k] !== e) begin fails++; $display("FAIL fill_beat%0d got %h exp %h", k, (beats.size() > k) ? beats[k] : 69'h0, e); end
    end
  endtask

  task automatic test_raw();
    bus_ready_in = 1'b0; beats.delete();
    wr1(32'h200, 32'hCAFE0001, 4'hF);
    core_rd_req_in = 1'b1; core_addr_in = 32'h202;
    repeat (3) begin
      @(negedge clk_in);
      tests++; if (stall_out !== 1'b1 || (bus_valid_out && !bus_we_out)) begin fails++; $display("FAIL raw_hold got stall=%b v=%b we=%b exp stall 1 no read", stall_out, bus_valid_out, bus_we_out); end
      step();
    end
    bus_ready_in = 1'b1;
    serve_read("raw", 3, 32'h12345678);
    tests++; if (beats.size() != 2 || beats[0] !== {1'b1, 32'h200, 32'hCAFE0001, 4'hF} || beats[1] !== {1'b0, 32'h200, 32'h0, 4'hF}) begin fails++; $display("FAIL raw_order got n=%0d %h %h exp write 200 then read 200", beats.size(), beats[0], beats[1]); end
  endtask

  task automatic test_read_priority();
    logic [68:0] e[3];
    e = '{{1'b1, 32'h500, 32'h55, 4'hF}, {1'b0, 32'h400, 32'h0, 4'hF}, {1'b1, 32'h504, 32'h66, 4'hF}};
    bus_ready_in = 1'b1; beats.delete();
    wr1(32'h500, 32'h55, 4'hF);
    wr1(32'h504, 32'h66, 4'hF);
    core_rd_req_in = 1'b1; core_addr_in = 32'h400;
    serve_read("prio", 1, 32'hA5A5A5A5);
    repeat (8) step();
    tests++; if (beats.size() != 3) begin fails++; $display("FAIL prio_count got %0d beats exp 3", beats.size()); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (beats.size() <= k || beats[k] !== e[k]) begin fails++; $display("FAIL prio_beat%0d got %h exp %h", k, (beats.size() > k) ? beats[k] : 69'h0, e[k]); end
    end
  endtask

  task automatic test_coalesce();
    logic [68:0] e[$];
    e.push_back({1'b1, 32'h2F0, 32'h11111111, 4'hF});
`ifdef DMEM_WB_COALESCE_EN
    e.push_back({1'b1, 32'h300, 32'h0000BBAA, 4'h3});
`else
    e.push_back({1'b1, 32'h300, 32'h000000AA, 4'h1});
    e.push_back({1'b1, 32'h300, 32'h0000BB00, 4'h2});
`endif
    bus_ready_in = 1'b0; beats.delete();
    wr1(32'h2F0, 32'h11111111, 4'hF);
    wr1(32'h300, 32'h000000AA, 4'h1);
    wr1(32'h300, 32'h0000BB00, 4'h2);
    bus_ready_in = 1'b1;
    repeat (10) step();
    tests++; if (beats.size() != e.size()) begin fails++; $display("FAIL coal_count got %0d beats exp %0d", beats.size(), e.size()); end
    foreach (e[k]) begin
      tests++; if (beats.size() <= k || beats[k] !== e[k]) begin fails++; $display("FAIL coal_beat%0d got %h exp %h", k, (beats.size() > k) ? beats[k] : 69'h0, e[k]); end
    end
  endtask

  task automatic test_mid_reset();
    bus_ready_in = 1'b0;
    wr1(32'h600, 32'h6, 4'hF);
    wr1(32'h604, 32'h7, 4'hF);
    @(negedge clk_in);
    tests++; if (bus_valid_out !== 1'b1) begin fails++; $display("FAIL mrst_pre valid got %b exp 1", bus_valid_out); end
    rst_in = 1'b0;
    step();
    @(negedge clk_in);
    tests++; if (bus_valid_out !== 1'b0 || dut.u_fifo.empty !== 1'b1) begin fails++; $display("FAIL mrst_abandon got valid=%b empty=%b exp 0 1", bus_valid_out, dut.u_fifo.empty); end
    rst_in = 1'b1; bus_ready_in = 1'b1; beats.delete();
    repeat (6) step();
    tests++; if (beats.size() != 0) begin fails++; $display("FAIL mrst_discard got %0d beats exp 0", beats.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_raw();
    test_read_priority();
    test_coalesce();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
